cnt_bank_sched: RTL and testbench

Arbitrated controller for a shared bank of 8-bit counters. After reset it runs a clear sweep over the bank. It then shares the bank between NREQ requesters using round-robin arbitration, executing one increment, clear or load operation per grant. It sits between the per-block control logic and the counter storage; the storage lives inside this block and is exported flat for observation.

---
 rtl/cnt_bank_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/cnt_bank_sched.sv | 162 ++++++++++++++++
 tb/tb_cnt_bank_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_bank_pkg.sv
// rtl/cnt_bank_pkg.sv - shared opcodes, FSM states and defaults for the counter bank scheduler
package cnt_bank_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int CNT_NCNT_DEF = 8;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_ARB  = 2'd1,
    S_EXEC = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr_i, wrapping
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            any_o,
  output logic [NREQ-1:0] win_oh_o,
  output logic [PW-1:0]   win_idx_o
);

  int   cand;
  logic found;

  always_comb begin
    cand      = 0;
    found     = 1'b0;
    win_oh_o  = '0;
    win_idx_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        win_oh_o[cand]  = 1'b1;
        win_idx_o       = PW'(cand);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/cnt_bank_sched.sv
// rtl/cnt_bank_sched.sv - round-robin shared 8-bit counter bank with init clear sweep
module cnt_bank_sched
  import cnt_bank_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NCNT = CNT_NCNT_DEF,
  parameter int W    = CNT_W_DEF,
  parameter int IDXW = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  input  logic [W*NREQ-1:0]    wdata,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic [W-1:0]         rdata,
  output logic                 ovf,
  output logic                 err,
  output logic                 busy,
  output logic [W*NCNT-1:0]    cnt_flat
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q;
  logic [IDXW-1:0] sweep_q;
  logic [PW-1:0]   rr_q;
  logic [W-1:0]    cnt_q [NCNT];
  logic [NREQ-1:0] gnt_q;
  logic            done_q, ovf_q, err_q, busy_q;
  logic [W-1:0]    rdata_q;
  logic [PW-1:0]   win_q;
  logic [1:0]      op_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    wdata_q;

  logic            any_req;
  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic [1:0]      sel_op;
  logic [IDXW-1:0] sel_idx;
  logic [W-1:0]    sel_wdata;

  logic [W-1:0]    cur_d, val_d;
  logic            hit_d, ovf_d;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i     (req),
    .ptr_i     (rr_q),
    .any_o     (any_req),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  always_comb begin
    sel_op    = '0;
    sel_idx   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        sel_op    = op[2*i +: 2];
        sel_idx   = idx[IDXW*i +: IDXW];
        sel_wdata = wdata[W*i +: W];
      end
    end
  end

  // Out-of-range indices simply never hit, so they fall through to err with rdata 0
  always_comb begin
    cur_d = '0;
    hit_d = 1'b0;
    for (int k = 0; k < NCNT; k++) begin
      if (idx_q == IDXW'(k)) begin
        hit_d = 1'b1;
        cur_d = cnt_q[k];
      end
    end
    case (op_q)
      OP_INC:  val_d = cur_d + 1'b1;
      OP_CLR:  val_d = '0;
      OP_LOAD: val_d = wdata_q;
      OP_NOP:  val_d = cur_d;
      default: val_d = cur_d;
    endcase
    if (!hit_d) val_d = '0;
    ovf_d = hit_d && (op_q == OP_INC) && (cur_d == {W{1'b1}});
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      rr_q    <= '0;
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
      rdata_q <= '0;
      win_q   <= '0;
      op_q    <= OP_NOP;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_INIT: begin
          for (int k = 0; k < NCNT; k++) begin
            if (sweep_q == IDXW'(k)) cnt_q[k] <= '0;
          end
          if (sweep_q == IDXW'(NCNT-1)) begin
            state_q <= S_ARB;
            busy_q  <= 1'b0;
          end else begin
            sweep_q <= sweep_q + 1'b1;
          end
        end
        S_ARB: begin
          if (any_req) begin
            state_q <= S_EXEC;
            gnt_q   <= win_oh;
            win_q   <= win_idx;
            op_q    <= sel_op;
            idx_q   <= sel_idx;
            wdata_q <= sel_wdata;
          end
        end
        S_EXEC: begin
          state_q <= S_ARB;
          done_q  <= 1'b1;
          rdata_q <= val_d;
          ovf_q   <= ovf_d;
          err_q   <= !hit_d;
          for (int k = 0; k < NCNT; k++) begin
            if (hit_d && idx_q == IDXW'(k)) cnt_q[k] <= val_d;
          end
          if (int'(win_q) == NREQ-1) rr_q <= '0;
          else                       rr_q <= win_q + 1'b1;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign ovf   = ovf_q;
  assign err   = err_q;
  assign busy  = busy_q;

  for (genvar k = 0; k < NCNT; k++) begin : g_flat
    assign cnt_flat[k*W +: W] = cnt_q[k];
  end

endmodule

// File: tb/tb_cnt_bank_sched.sv
// tb/tb_cnt_bank_sched.sv - directed bench with a cycle-level behavioural model and literal spot checks
module tb_cnt_bank_sched;
  import cnt_bank_pkg::*;

  localparam int NREQ = 4;
  localparam int NCNT = 8;
  localparam int W    = 8;
  localparam int IDXW = 4;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [2*NREQ-1:0]    op = '0;
  logic [IDXW*NREQ-1:0] idx = '0;
  logic [W*NREQ-1:0]    wdata = '0;
  logic [NREQ-1:0]      gnt;
  logic                 done, ovf, err, busy;
  logic [W-1:0]         rdata;
  logic [W*NCNT-1:0]    cnt_flat;

  cnt_bank_sched #(.NREQ(NREQ), .NCNT(NCNT), .W(W), .IDXW(IDXW)) dut (
    .CLK(CLK), .RST(RST), .req(req), .op(op), .idx(idx), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .ovf(ovf), .err(err),
    .busy(busy), .cnt_flat(cnt_flat)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   mcnt [NCNT];
  int   mrr, minit;
  bit   mpend;
  int   pwin, pop, pidx, pwd;
  int   e_gnt, e_done, e_ovf, e_err, e_rdata;
  logic [NREQ-1:0]      p_req;
  logic [2*NREQ-1:0]    p_op;
  logic [IDXW*NREQ-1:0] p_idx;
  logic [W*NREQ-1:0]    p_wd;
  bit   prev_rst = 1'b0;
  bit   started  = 1'b0;

  task automatic m_reset();
    for (int k = 0; k < NCNT; k++) mcnt[k] = 0;
    mrr = 0; minit = 0; mpend = 0;
    e_gnt = 0; e_done = 0; e_ovf = 0; e_err = 0; e_rdata = 0;
  endtask

  task automatic m_step();
    int c, nv;
    bit found;
    e_gnt = 0; e_done = 0; e_ovf = 0; e_err = 0;
    if (minit < NCNT) begin
      minit++;
    end else if (mpend) begin
      mpend  = 0;
      e_done = 1;
      if (pidx < NCNT) begin
        nv = mcnt[pidx];
        if (pop == 1) begin
          e_ovf = (mcnt[pidx] == 255) ? 1 : 0;
          nv = (mcnt[pidx] + 1) % 256;
        end else if (pop == 2) nv = 0;
        else if (pop == 3) nv = pwd;
        mcnt[pidx] = nv;
        e_rdata    = nv;
      end else begin
        e_err   = 1;
        e_rdata = 0;
      end
      mrr = (pwin + 1) % NREQ;
    end else begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        c = (mrr + k) % NREQ;
        if (!found && p_req[c]) begin
          found = 1;
          pwin  = c;
        end
      end
      if (found) begin
        mpend = 1;
        e_gnt = 1 << pwin;
        pop   = int'(p_op[2*pwin +: 2]);
        pidx  = int'(p_idx[IDXW*pwin +: IDXW]);
        pwd   = int'(p_wd[W*pwin +: W]);
      end
    end
  endtask

  initial begin
    logic [63:0] ef;
    m_reset();
    forever begin
      @(negedge CLK);
      if (started) begin
        if (!RST) m_reset();
        else if (prev_rst) m_step();
        ef = '0;
        for (int k = 0; k < NCNT; k++) ef[k*W +: W] = mcnt[k][W-1:0];
        check("cyc_gnt",   64'(gnt),   64'(e_gnt));
        check("cyc_done",  64'(done),  64'(e_done));
        check("cyc_ovf",   64'(ovf),   64'(e_ovf));
        check("cyc_err",   64'(err),   64'(e_err));
        check("cyc_rdata", 64'(rdata), 64'(e_rdata));
        check("cyc_busy",  64'(busy),  64'(minit < NCNT));
        check("cyc_cnt",   cnt_flat,   ef);
      end
      p_req = req; p_op = op; p_idx = idx; p_wd = wdata;
      prev_rst = RST;
    end
  end

  // ---------------- requester driver ----------------
  typedef struct {
    logic [1:0]      o;
    logic [IDXW-1:0] i;
    logic [W-1:0]    d;
  } tr_t;

  tr_t qs [NREQ][$];
  int  gnt_log[$], gnt_cyc[$], done_rd[$], done_ovf[$], done_err[$];
  int  cyc = 0;

  task automatic push(input int r, input logic [1:0] o, input int i, input int d);
    tr_t t;
    t.o = o; t.i = IDXW'(i); t.d = W'(d);
    qs[r].push_back(t);
  endtask

  task automatic present();
    for (int r = 0; r < NREQ; r++) begin
      if (qs[r].size() > 0) begin
        req[r]              = 1'b1;
        op[2*r +: 2]        = qs[r][0].o;
        idx[IDXW*r +: IDXW] = qs[r][0].i;
        wdata[W*r +: W]     = qs[r][0].d;
      end else begin
        req[r] = 1'b0;
      end
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete(); gnt_cyc.delete();
    done_rd.delete(); done_ovf.delete(); done_err.delete();
  endtask

  task automatic tick();
    tr_t t;
    @(posedge CLK);
    #1;
    cyc++;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt[r]) begin
        gnt_log.push_back(r);
        gnt_cyc.push_back(cyc);
        if (qs[r].size() > 0) t = qs[r].pop_front();
      end
    end
    if (done) begin
      done_rd.push_back(int'(rdata));
      done_ovf.push_back(int'(ovf));
      done_err.push_back(int'(err));
    end
    present();
  endtask

  function automatic int at(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  task automatic wait_done(input int n, input string name);
    int b = 0;
    while (done_rd.size() < n && b < 300) begin
      tick();
      b++;
    end
    check({name, "_timeout"}, 64'(done_rd.size() >= n), 64'd1);
  endtask

  task automatic release_and_count_busy(input string name);
    int n = 0;
    tick();
    RST = 1'b1;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    check(name, 64'(n), 64'd8);
  endtask

  initial begin
    int b;
    logic [63:0] snap;
    #2 RST = 1'b0;
    started = 1'b1;

    // T1: held inc on idx 2 from requester 0 across the init sweep
    push(0, OP_INC, 2, 0);
    present();
    tick(); tick();
    check("t1_reset_cnt", cnt_flat, 64'd0);
    check("t1_reset_busy", 64'(busy), 64'd1);
    release_and_count_busy("t1_busy_cycles");
    check("t1_no_gnt_in_init", 64'(gnt_log.size()), 64'd0);
    check("t1_cnt_after_init", cnt_flat, 64'd0);
    wait_done(1, "t1");
    check("t1_gnt", 64'(at(gnt_log, 0)), 64'd0);
    check("t1_rdata", 64'(at(done_rd, 0)), 64'd1);
    check("t1_cnt2", 64'(cnt_flat[2*W +: W]), 64'd1);

    // T2: all four requesters inc counter 0, requester 0 twice
    RST = 1'b0;
    tick();
    clear_logs();
    push(0, OP_INC, 0, 0); push(0, OP_INC, 0, 0);
    push(1, OP_INC, 0, 0); push(2, OP_INC, 0, 0); push(3, OP_INC, 0, 0);
    present();
    release_and_count_busy("t2_busy_cycles");
    wait_done(5, "t2");
    for (int k = 0; k < 5; k++) begin
      check("t2_gnt_order", 64'(at(gnt_log, k)), 64'((k == 4) ? 0 : k));
      check("t2_rdata", 64'(at(done_rd, k)), 64'(k + 1));
    end
    for (int k = 0; k < 4; k++)
      check("t2_gnt_gap", 64'(at(gnt_cyc, k + 1) - at(gnt_cyc, k)), 64'd2);

    // T3: load FF then inc wraps with ovf on the second op only
    clear_logs();
    push(1, OP_LOAD, 5, 8'hFF); push(1, OP_INC, 5, 0);
    present();
    wait_done(2, "t3");
    check("t3_rdata0", 64'(at(done_rd, 0)), 64'hFF);
    check("t3_rdata1", 64'(at(done_rd, 1)), 64'h00);
    check("t3_ovf0", 64'(at(done_ovf, 0)), 64'd0);
    check("t3_ovf1", 64'(at(done_ovf, 1)), 64'd1);

    // T4: idx 7 in range, idx 9 out of range
    clear_logs();
    push(2, OP_INC, 7, 0); push(2, OP_INC, 9, 0);
    present();
    wait_done(1, "t4a");
    snap = cnt_flat;
    wait_done(2, "t4b");
    check("t4_rdata7", 64'(at(done_rd, 0)), 64'd1);
    check("t4_err7", 64'(at(done_err, 0)), 64'd0);
    check("t4_rdata9", 64'(at(done_rd, 1)), 64'd0);
    check("t4_err9", 64'(at(done_err, 1)), 64'd1);
    check("t4_cnt_unchanged", cnt_flat, snap);

    // T5: reset lands in the EXEC cycle of a load
    clear_logs();
    push(1, OP_LOAD, 3, 8'h55);
    present();
    b = 0;
    while (gnt_log.size() == 0 && b < 100) begin
      tick();
      b++;
    end
    check("t5_gnt_timeout", 64'(gnt_log.size() > 0), 64'd1);
    RST = 1'b0;
    tick(); tick(); tick();
    check("t5_no_done", 64'(done_rd.size()), 64'd0);
    clear_logs();
    push(3, OP_INC, 1, 0); push(0, OP_INC, 1, 0);
    present();
    release_and_count_busy("t5_busy_cycles");
    check("t5_cnt3", 64'(cnt_flat[3*W +: W]), 64'd0);
    wait_done(2, "t5");
    check("t5_first_gnt", 64'(at(gnt_log, 0)), 64'd0);
    check("t5_second_gnt", 64'(at(gnt_log, 1)), 64'd3);
    check("t5_rdata1", 64'(at(done_rd, 1)), 64'd2);

    // T6: load 10, clr, nop on counter 4
    clear_logs();
    push(2, OP_LOAD, 4, 8'h10); push(2, OP_CLR, 4, 0); push(2, OP_NOP, 4, 0);
    present();
    wait_done(3, "t6");
    check("t6_load", 64'(at(done_rd, 0)), 64'h10);
    check("t6_clr", 64'(at(done_rd, 1)), 64'h00);
    check("t6_nop", 64'(at(done_rd, 2)), 64'h00);
    check("t6_flags", 64'(at(done_ovf, 1) + at(done_ovf, 2) + at(done_err, 1) + at(done_err, 2)), 64'd0);

    tick(); tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
